// File: rtl/flags_pipe_if.sv
// flags_pipe_if -- bundle of the E-stage flag-update request, pipeline control,
// save/restore requests and the flag outputs of flags_pipe.
//
// Handshake: e_valid qualifies e_flag_write/e_cond_ex/e_alu_flags in the
// cycle it is high. A request is taken on a rising edge only when stall=0 and
// flush=0. There is no ready signal; the stall input is the only back-pressure,
// and the producer must hold its request while stall=1 if it wants it taken.
//
// Signals (direction as seen by flags_pipe, the slave):
//   e_valid, e_flag_write[1:0], e_cond_ex, e_alu_flags[3:0]  in   E-stage request
//   stall, flush                                              in   pipeline control
//   save_req, restore_req                                     in   shadow control
//   flags[3:0], flags_fwd[3:0], pend_valid                    out  flag state
//   upd_count[CNT_W-1:0]                                      out  commit counter
interface flags_pipe_if #(
  parameter int CNT_W = 16
);
  logic             e_valid;
  logic [1:0]       e_flag_write;
  logic             e_cond_ex;
  logic [3:0]       e_alu_flags;
  logic             stall;
  logic             flush;
  logic             save_req;
  logic             restore_req;
  logic [3:0]       flags;
  logic [3:0]       flags_fwd;
  logic             pend_valid;
  logic [CNT_W-1:0] upd_count;

  modport master (
    output e_valid, e_flag_write, e_cond_ex, e_alu_flags,
    output stall, flush, save_req, restore_req,
    input  flags, flags_fwd, pend_valid, upd_count
  );

  modport slave (
    input  e_valid, e_flag_write, e_cond_ex, e_alu_flags,
    input  stall, flush, save_req, restore_req,
    output flags, flags_fwd, pend_valid, upd_count
  );
endinterface

// File: rtl/flags_pipe.sv
// flags_pipe -- owner of the architectural NZCV flags register.
// An E-stage flag update is captured into a one-entry M-stage pending slot,
// forwarded combinationally on flags_fwd, and committed into flags on the
// following edge unless stalled, flushed or overridden by a restore.
// A one-entry shadow supports save/restore around exceptions, and a saturating
// counter records the number of committed updates.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of flags_pipe_if (request, control and flag outputs)
//
// Bit order of every flag vector: [3]=N, [2]=Z, [1]=C, [0]=V.
module flags_pipe #(
  parameter int         CNT_W       = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic         clk,
  input  logic         rst_n,
  flags_pipe_if.slave  bus
);

  logic [3:0]       flags_q;
  logic [3:0]       shadow_q;
  logic             pend_valid_q;
  logic [3:0]       pend_mask_q;
  logic [3:0]       pend_data_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]       e_mask;
  logic             capture;
  logic             commit;
  logic [3:0]       merged;
  logic [3:0]       post_commit;

  // wr[1] covers N,Z and wr[0] covers C,V.
  assign e_mask  = {{2{bus.e_flag_write[1]}}, {2{bus.e_flag_write[0]}}};
  assign capture = bus.e_valid & bus.e_cond_ex & (|bus.e_flag_write);
  assign commit  = pend_valid_q & ~bus.stall & ~bus.flush;

  // Pending entry laid over the committed flags; unmasked bits keep their value.
  assign merged      = (flags_q & ~pend_mask_q) | (pend_data_q & pend_mask_q);
  // Value flags would take this edge if no restore were requested; save
  // captures this so a save coincident with a commit sees the new flags.
  assign post_commit = commit ? merged : flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= RESET_FLAGS;
      shadow_q     <= RESET_FLAGS;
      pend_valid_q <= 1'b0;
      pend_mask_q  <= 4'b0000;
      pend_data_q  <= 4'b0000;
      cnt_q        <= '0;
    end else begin
      // A restore overrides the commit; the dropped commit is still counted.
      flags_q <= bus.restore_req ? shadow_q : post_commit;

      if (bus.save_req) begin
        shadow_q <= post_commit;
      end

      if (commit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Flush beats stall; a restore also discards the pending entry and
      // the same-edge E request.
      if (bus.flush || bus.restore_req) begin
        pend_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        pend_valid_q <= capture;
        pend_mask_q  <= e_mask;
        pend_data_q  <= bus.e_alu_flags;
      end
    end
  end

  assign bus.flags      = flags_q;
  assign bus.flags_fwd  = pend_valid_q ? merged : flags_q;
  assign bus.pend_valid = pend_valid_q;
  assign bus.upd_count  = cnt_q;

endmodule

// File: tb/tb_flags_pipe.sv
module tb_flags_pipe;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] RF      = 4'b0110;
  localparam int         CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  flags_pipe_if #(.CNT_W(CNT_W)) ifc ();

  flags_pipe #(.CNT_W(CNT_W), .RESET_FLAGS(RF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Pending M-stage updates as {wr[1:0], data[3:0]}; holds zero or one entry.
  logic [5:0] exp_q[$];
  logic [3:0] m_flags;
  logic [3:0] m_shadow;
  int         m_cnt;

  // Field-level update: each enabled pair takes the ALU bits, the rest stay.
  function automatic logic [3:0] apply_upd(logic [3:0] f, logic [1:0] wr, logic [3:0] d);
    logic [3:0] r;
    r = f;
    if (wr[1]) r[3:2] = d[3:2];
    if (wr[0]) r[1:0] = d[1:0];
    return r;
  endfunction

  function automatic logic [3:0] exp_fwd();
    logic [5:0] e;
    if (exp_q.size() == 0) return m_flags;
    e = exp_q[0];
    return apply_upd(m_flags, e[5:4], e[3:0]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_flags  = RF;
    m_shadow = RF;
    m_cnt    = 0;
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    ifc.e_valid      = 1'b0;
    ifc.e_flag_write = 2'b00;
    ifc.e_cond_ex    = 1'b0;
    ifc.e_alu_flags  = 4'b0000;
    ifc.stall        = 1'b0;
    ifc.flush        = 1'b0;
    ifc.save_req     = 1'b0;
    ifc.restore_req  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs, step the model at the edge, return at negedge.
  task automatic cycle(input logic ev, input logic [1:0] wr, input logic cond,
                       input logic [3:0] alu, input logic st, input logic fl,
                       input logic sv, input logic rs);
    logic       do_commit;
    logic [3:0] post;
    logic [5:0] e;
    ifc.e_valid      = ev;
    ifc.e_flag_write = wr;
    ifc.e_cond_ex    = cond;
    ifc.e_alu_flags  = alu;
    ifc.stall        = st;
    ifc.flush        = fl;
    ifc.save_req     = sv;
    ifc.restore_req  = rs;
    @(posedge clk);
    do_commit = (exp_q.size() != 0) && !st && !fl;
    post = m_flags;
    if (do_commit) begin
      e = exp_q[0];
      post = apply_upd(m_flags, e[5:4], e[3:0]);
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
    m_flags = rs ? m_shadow : post;
    if (sv) m_shadow = post;
    if (fl || rs) begin
      exp_q.delete();
    end else if (!st) begin
      exp_q.delete();
      if (ev && cond && (wr != 2'b00)) exp_q.push_back({wr, alu});
    end
    @(negedge clk);
  endtask

  task automatic upd(input logic [1:0] wr, input logic [3:0] alu);
    cycle(1'b1, wr, 1'b1, alu, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    cycle(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (ifc.flags !== RF) begin errors++; $display("FAIL reset_flags: got %b expected %b", ifc.flags, RF); end
    checks++; if (ifc.flags_fwd !== RF) begin errors++; $display("FAIL reset_fwd: got %b expected %b", ifc.flags_fwd, RF); end
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", ifc.pend_valid); end
    checks++; if (ifc.upd_count !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", ifc.upd_count); end
  endtask

  task automatic test_latency();
    upd(2'b11, 4'b1010);
    checks++; if (ifc.flags_fwd !== 4'b1010) begin errors++; $display("FAIL lat_fwd_e1: got %b expected 1010", ifc.flags_fwd); end
    checks++; if (ifc.flags !== RF) begin errors++; $display("FAIL lat_flags_e1: got %b expected %b", ifc.flags, RF); end
    checks++; if (ifc.pend_valid !== 1'b1) begin errors++; $display("FAIL lat_pend_e1: got %b expected 1", ifc.pend_valid); end
    nop();
    checks++; if (ifc.flags !== 4'b1010) begin errors++; $display("FAIL lat_flags_e2: got %b expected 1010", ifc.flags); end
    checks++; if (ifc.upd_count !== 4'd1) begin errors++; $display("FAIL lat_cnt: got %0d expected 1", ifc.upd_count); end
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL lat_pend_e2: got %b expected 0", ifc.pend_valid); end
  endtask

  task automatic test_back_to_back();
    upd(2'b11, 4'b1111);
    upd(2'b10, 4'b0100);
    checks++; if (ifc.flags !== 4'b1111) begin errors++; $display("FAIL b2b_flags1: got %b expected 1111", ifc.flags); end
    checks++; if (ifc.flags_fwd !== 4'b0111) begin errors++; $display("FAIL b2b_fwd1: got %b expected 0111", ifc.flags_fwd); end
    upd(2'b01, 4'b0000);
    checks++; if (ifc.flags !== 4'b0111) begin errors++; $display("FAIL b2b_nz_only: got %b expected 0111", ifc.flags); end
    checks++; if (ifc.flags_fwd !== 4'b0100) begin errors++; $display("FAIL b2b_fwd2: got %b expected 0100", ifc.flags_fwd); end
    nop();
    checks++; if (ifc.flags !== 4'b0100) begin errors++; $display("FAIL b2b_cv_only: got %b expected 0100", ifc.flags); end
    checks++; if (ifc.upd_count !== 4'd4) begin errors++; $display("FAIL b2b_cnt: got %0d expected 4", ifc.upd_count); end
  endtask

  task automatic test_stall_flush();
    upd(2'b11, 4'b0001);
    checks++; if (ifc.flags_fwd !== 4'b0001) begin errors++; $display("FAIL sf_fwd0: got %b expected 0001", ifc.flags_fwd); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b11, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (ifc.flags_fwd !== 4'b0001) begin errors++; $display("FAIL sf_stall_fwd[%0d]: got %b expected 0001", i, ifc.flags_fwd); end
      checks++; if (ifc.flags !== 4'b0100) begin errors++; $display("FAIL sf_stall_flags[%0d]: got %b expected 0100", i, ifc.flags); end
      checks++; if (ifc.pend_valid !== 1'b1) begin errors++; $display("FAIL sf_stall_pend[%0d]: got %b expected 1", i, ifc.pend_valid); end
    end
    // Flush with stall still high and a live E request: flush wins.
    cycle(1'b1, 2'b11, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL sf_flush_pend: got %b expected 0", ifc.pend_valid); end
    checks++; if (ifc.flags_fwd !== 4'b0100) begin errors++; $display("FAIL sf_flush_fwd: got %b expected 0100", ifc.flags_fwd); end
    nop();
    checks++; if (ifc.flags !== 4'b0100) begin errors++; $display("FAIL sf_flags: got %b expected 0100", ifc.flags); end
    checks++; if (ifc.upd_count !== 4'd4) begin errors++; $display("FAIL sf_cnt: got %0d expected 4", ifc.upd_count); end
  endtask

  task automatic test_no_update();
    cycle(1'b1, 2'b11, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL nu_cond: got %b expected 0", ifc.pend_valid); end
    cycle(1'b1, 2'b00, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL nu_wr0: got %b expected 0", ifc.pend_valid); end
    cycle(1'b0, 2'b11, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL nu_inval: got %b expected 0", ifc.pend_valid); end
    nop();
    checks++; if (ifc.flags !== 4'b0100) begin errors++; $display("FAIL nu_flags: got %b expected 0100", ifc.flags); end
    checks++; if (ifc.upd_count !== 4'd4) begin errors++; $display("FAIL nu_cnt: got %0d expected 4", ifc.upd_count); end
  endtask

  task automatic test_save_restore();
    upd(2'b11, 4'b1000);
    nop();
    cycle(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);   // save 1000
    upd(2'b11, 4'b0110);
    upd(2'b11, 4'b0011);
    checks++; if (ifc.flags !== 4'b0110) begin errors++; $display("FAIL sr_pre: got %b expected 0110", ifc.flags); end
    cycle(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);   // restore over commit
    checks++; if (ifc.flags !== 4'b1000) begin errors++; $display("FAIL sr_restore: got %b expected 1000", ifc.flags); end
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL sr_pend: got %b expected 0", ifc.pend_valid); end
    checks++; if (ifc.flags_fwd !== 4'b1000) begin errors++; $display("FAIL sr_fwd: got %b expected 1000", ifc.flags_fwd); end
    checks++; if (ifc.upd_count !== 4'd7) begin errors++; $display("FAIL sr_cnt: got %0d expected 7", ifc.upd_count); end
    // Swap: shadow takes the post-commit value, flags take the old shadow.
    upd(2'b11, 4'b0001);
    cycle(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (ifc.flags !== 4'b1000) begin errors++; $display("FAIL sr_swap_flags: got %b expected 1000", ifc.flags); end
    cycle(1'b0, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (ifc.flags !== 4'b0001) begin errors++; $display("FAIL sr_swap_shadow: got %b expected 0001", ifc.flags); end
  endtask

  task automatic test_async_reset();
    upd(2'b11, 4'b1111);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.flags !== RF) begin errors++; $display("FAIL ar_flags: got %b expected %b", ifc.flags, RF); end
    checks++; if (ifc.flags_fwd !== RF) begin errors++; $display("FAIL ar_fwd: got %b expected %b", ifc.flags_fwd, RF); end
    checks++; if (ifc.pend_valid !== 1'b0) begin errors++; $display("FAIL ar_pend: got %b expected 0", ifc.pend_valid); end
    checks++; if (ifc.upd_count !== 4'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", ifc.upd_count); end
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    checks++; if (ifc.flags !== RF) begin errors++; $display("FAIL ar_nocommit: got %b expected %b", ifc.flags, RF); end
  endtask

  task automatic test_saturation();
    logic [3:0] d;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      d = 4'($urandom_range(0, 15));
      upd(2'b11, d);
    end
    nop();
    checks++; if (ifc.upd_count !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", ifc.upd_count); end
    checks++; if (ifc.flags !== d) begin errors++; $display("FAIL sat_flags: got %b expected %b", ifc.flags, d); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      checks++; if (ifc.flags !== m_flags) begin errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, ifc.flags, m_flags); end
      checks++; if (ifc.flags_fwd !== exp_fwd()) begin errors++; $display("FAIL rnd_fwd[%0d]: got %b expected %b", i, ifc.flags_fwd, exp_fwd()); end
      checks++; if (ifc.pend_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_pend[%0d]: got %b expected %0d", i, ifc.pend_valid, exp_q.size()); end
      checks++; if (ifc.upd_count !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, ifc.upd_count, m_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall_flush();
    test_no_update();
    test_save_restore();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
